// File: rtl/mem_write_checker.sv
// -----------------------------------------------------------------------------
// mem_write_checker
//
// Purpose:
//   This module watches a processor's store port and checks it against a
//   small table of expected {address, data} writes. The table is loaded while
//   the checker is IDLE. A start pulse begins a run, and the monitored stores
//   are compared in order against the table. The run ends in PASS when every
//   loaded entry has matched, in FAIL on the first wrong store, or in TOUT if
//   the run does not finish in time. PASS, FAIL and TOUT hold until the next
//   start or a reset. A reset also empties the table.
//
// Build option:
//   MWC_SCRATCH_EN - when defined, RUN ignores stores whose address lies in
//                    the inclusive window [SCRATCH_LO, SCRATCH_HI]. When it is
//                    undefined, every store in RUN is compared.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   one-cycle pulse that begins a run (needs >=1 loaded entry)
//   load_valid   in   in IDLE, appends {load_addr, load_data} to the table
//   load_addr    in   [ADDR_W] expected store address
//   load_data    in   [DATA_W] expected store data
//   memwrite     in   monitored store strobe
//   dataadr      in   [ADDR_W] monitored store address
//   writedata    in   [DATA_W] monitored store data
//   busy         out  high only in RUN
//   pass         out  high only in PASS
//   fail         out  high only in FAIL
//   timeout      out  high only in TOUT
//   fail_idx     out  [IDX_W] table index of the mismatching entry
//   fail_addr    out  [ADDR_W] captured address of the offending store
//   fail_data    out  [DATA_W] captured data of the offending store
//   match_count  out  [CNT_W] entries matched in the current or last run
//   o_dbg_state  out  [3] raw FSM state (IDLE=0 RUN=1 PASS=2 FAIL=3 TOUT=4)
//
// Handshake: nothing here is back-pressured. load_valid and memwrite are
// single-cycle strobes, and their payload is taken on the same rising edge.
// A store counts once for each cycle in which memwrite is sampled high.
// -----------------------------------------------------------------------------
module mem_write_checker #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 20,
    parameter int SCRATCH_LO = 80,
    parameter int SCRATCH_HI = 80,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int TCNT_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_count,
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TOUT = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_n_loaded;
    logic [CNT_W-1:0]  r_match_count;
    logic [TCNT_W-1:0] r_cycle;
    logic [IDX_W-1:0]  r_fail_idx;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;

    // Table storage has no reset. Emptying the table only needs r_n_loaded
    // to be cleared.
    logic [ADDR_W-1:0] r_tab_addr [DEPTH];
    logic [DATA_W-1:0] r_tab_data [DEPTH];

    logic              w_in_scratch;
    logic              w_full;
    logic              w_load_ok;
    logic              w_start_ok;
    logic              w_cmp_en;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_last;
    logic              w_tmo;

`ifdef MWC_SCRATCH_EN
    assign w_in_scratch = (dataadr >= ADDR_W'(SCRATCH_LO)) &&
                          (dataadr <= ADDR_W'(SCRATCH_HI));
`else
    logic w_unused_scratch;
    assign w_unused_scratch = ^{ADDR_W'(SCRATCH_LO), ADDR_W'(SCRATCH_HI)};
    assign w_in_scratch     = 1'b0;
`endif

    assign w_full     = (r_n_loaded == CNT_W'(DEPTH));
    assign w_load_ok  = (r_state == S_IDLE) && load_valid && !w_full;
    assign w_start_ok = start && (r_state != S_RUN) && (r_n_loaded != '0);
    assign w_cmp_en   = (r_state == S_RUN) && memwrite && !w_in_scratch;

    // While in RUN, match_count is always below n_loaded (which is at most
    // DEPTH), so the low bits are a valid table index.
    assign w_idx  = r_match_count[IDX_W-1:0];
    assign w_hit  = (r_tab_addr[w_idx] == dataadr) && (r_tab_data[w_idx] == writedata);
    assign w_last = ((r_match_count + CNT_W'(1)) == r_n_loaded);
    assign w_tmo  = (r_cycle == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset && w_load_ok) begin
            r_tab_addr[r_n_loaded[IDX_W-1:0]] <= load_addr;
            r_tab_data[r_n_loaded[IDX_W-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_n_loaded    <= '0;
            r_match_count <= '0;
            r_cycle       <= '0;
            r_fail_idx    <= '0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
        end else begin
            if (w_load_ok) begin
                r_n_loaded <= r_n_loaded + CNT_W'(1);
            end

            if (w_start_ok) begin
                r_state       <= S_RUN;
                r_match_count <= '0;
                r_cycle       <= '0;
                r_fail_idx    <= '0;
                r_fail_addr   <= '0;
                r_fail_data   <= '0;
            end else if (r_state == S_RUN) begin
                // The counter saturates at TIMEOUT and never wraps.
                if (r_cycle != TCNT_W'(TIMEOUT)) begin
                    r_cycle <= r_cycle + TCNT_W'(1);
                end
                // A store compared on the final cycle has priority over the
                // timeout, so a completing match still gives PASS.
                if (w_cmp_en) begin
                    if (w_hit) begin
                        r_match_count <= r_match_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_PASS;
                        end else if (w_tmo) begin
                            r_state <= S_TOUT;
                        end
                    end else begin
                        r_state     <= S_FAIL;
                        r_fail_idx  <= w_idx;
                        r_fail_addr <= dataadr;
                        r_fail_data <= writedata;
                    end
                end else if (w_tmo) begin
                    r_state <= S_TOUT;
                end
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign timeout     = (r_state == S_TOUT);
    assign fail_idx    = r_fail_idx;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign match_count = r_match_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    logic              clk;
    logic              reset;
    logic              start;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;
    logic              busy;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [1:0]        fail_idx;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic [2:0]        match_count;
    logic [2:0]        o_dbg_state;

    int checks = 0;
    int errors = 0;

    mem_write_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
        .SCRATCH_LO(80), .SCRATCH_HI(80)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data),
        .match_count(match_count), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, pass, fail, timeout} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, pass, fail, timeout});
        end
        checks++;
        if (match_count !== 3'd0 || fail_idx !== 2'd0) begin
            errors++; $display("FAIL reset_counts: got mc=%0d idx=%0d expected 0 0", match_count, fail_idx);
        end
        checks++;
        if (fail_addr !== 32'd0 || fail_data !== 32'd0) begin
            errors++; $display("FAIL reset_fail_bus: got %0d/%0d expected 0/0", fail_addr, fail_data);
        end
        checks++;
        if (o_dbg_state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
        end
        tick();
        reset = 1'b0;
        // start with an empty table must be ignored
        start_run();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL start_empty: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_scratch_pass();
        do_reset();
        load(32'd84, 32'd7);
        start_run();
        checks++;
        if (busy !== 1'b1 || match_count !== 3'd0) begin
            errors++; $display("FAIL run_entry: got busy=%b mc=%0d expected 1 0", busy, match_count);
        end
        store(32'd80, 32'd3);
`ifdef MWC_SCRATCH_EN
        checks++;
        if (busy !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL scratch_ignored: got busy=%b fail=%b expected 1 0", busy, fail);
        end
        store(32'd84, 32'd7);
        checks++;
        if (pass !== 1'b1 || busy !== 1'b0 || match_count !== 3'd1) begin
            errors++; $display("FAIL pass_one: got pass=%b busy=%b mc=%0d expected 1 0 1", pass, busy, match_count);
        end
        // sticky: a later store must not disturb PASS
        store(32'd88, 32'd1);
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL pass_sticky: got pass=%b fail=%b expected 1 0", pass, fail);
        end
`else
        checks++;
        if (fail !== 1'b1 || fail_addr !== 32'd80 || fail_data !== 32'd3 || fail_idx !== 2'd0) begin
            errors++; $display("FAIL no_window: got fail=%b addr=%0d data=%0d idx=%0d expected 1 80 3 0",
                               fail, fail_addr, fail_data, fail_idx);
        end
`endif
    endtask

    task automatic test_mismatch();
        do_reset();
        load(32'd84, 32'd7);
        start_run();
        // memwrite low: the address/data on the bus must be ignored
        dataadr = 32'd88; writedata = 32'd7;
        tick();
        checks++;
        if (busy !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL no_strobe: got busy=%b fail=%b expected 1 0", busy, fail);
        end
        store(32'd88, 32'd7);
        checks++;
        if (fail !== 1'b1 || busy !== 1'b0 || fail_idx !== 2'd0 ||
            fail_addr !== 32'd88 || fail_data !== 32'd7) begin
            errors++; $display("FAIL mismatch: got fail=%b busy=%b idx=%0d addr=%0d data=%0d expected 1 0 0 88 7",
                               fail, busy, fail_idx, fail_addr, fail_data);
        end
        // restart clears fail_* and enters RUN again
        start_run();
        checks++;
        if (busy !== 1'b1 || fail !== 1'b0 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
            errors++; $display("FAIL restart_clear: got busy=%b fail=%b addr=%0d data=%0d expected 1 0 0 0",
                               busy, fail, fail_addr, fail_data);
        end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        load(32'd84, 32'd7);
        start_run();               // RUN entered on this edge
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (timeout !== 1'b0 || busy !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: got %0d early cycles expected 0", early);
        end
        tick();                    // edge TIMEOUT after RUN entry
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || match_count !== 3'd0) begin
            errors++; $display("FAIL timeout: got tout=%b busy=%b mc=%0d expected 1 0 0", timeout, busy, match_count);
        end
    endtask

    task automatic test_timeout_edge();
        // matching store on the final cycle -> PASS
        do_reset();
        load(32'd84, 32'd7);
        start_run();
        for (int k = 1; k < TIMEOUT; k++) tick();
        store(32'd84, 32'd7);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL last_cycle_match: got pass=%b tout=%b expected 1 0", pass, timeout);
        end
        // wrong store on the final cycle -> FAIL
        start_run();
        for (int k = 1; k < TIMEOUT; k++) tick();
        store(32'd92, 32'd7);
        checks++;
        if (fail !== 1'b1 || timeout !== 1'b0 || fail_addr !== 32'd92) begin
            errors++; $display("FAIL last_cycle_miss: got fail=%b tout=%b addr=%0d expected 1 0 92", fail, timeout, fail_addr);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        load(32'd84, 32'd7);
        load(32'd88, 32'd9);
        start_run();
        store(32'd84, 32'd7);
        checks++;
        if (match_count !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL partial: got mc=%0d busy=%b expected 1 1", match_count, busy);
        end
        #2 reset = 1'b1;           // mid-cycle, no clock edge yet
        #1;
        checks++;
        if ({busy, pass, fail, timeout} !== 4'b0000 || match_count !== 3'd0 || o_dbg_state !== 3'd0) begin
            errors++; $display("FAIL async_reset: got flags=%b mc=%0d st=%0d expected 0000 0 0",
                               {busy, pass, fail, timeout}, match_count, o_dbg_state);
        end
        tick();
        reset = 1'b0;
        start_run();
        tick();
        checks++;
        if (busy !== 1'b0 || o_dbg_state !== 3'd0) begin
            errors++; $display("FAIL table_emptied: got busy=%b st=%0d expected 0 0", busy, o_dbg_state);
        end
    endtask

    task automatic test_depth();
        do_reset();
        for (int i = 0; i < 5; i++) load(32'(100 + 4 * i), 32'(i + 1));
        start_run();
        // load during RUN must not alter the table
        load(32'd200, 32'd55);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL depth_run: got busy=%b expected 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            store(32'(100 + 4 * i), 32'(i + 1));
            checks++;
            if (match_count !== 3'(i + 1) || busy !== 1'b1) begin
                errors++; $display("FAIL depth_step%0d: got mc=%0d busy=%b expected %0d 1", i, match_count, busy, i + 1);
            end
        end
        store(32'd112, 32'd4);
        checks++;
        if (pass !== 1'b1 || match_count !== 3'd4) begin
            errors++; $display("FAIL depth_pass: got pass=%b mc=%0d expected 1 4", pass, match_count);
        end
        // second run: wrong data on entry 2 reports index 2
        start_run();
        store(32'd100, 32'd1);
        store(32'd104, 32'd2);
        store(32'd108, 32'd9);
        checks++;
        if (fail !== 1'b1 || fail_idx !== 2'd2 || fail_data !== 32'd9 || match_count !== 3'd2) begin
            errors++; $display("FAIL depth_fail_idx: got fail=%b idx=%0d data=%0d mc=%0d expected 1 2 9 2",
                               fail, fail_idx, fail_data, match_count);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; memwrite = 1'b0;
        load_addr = '0; load_data = '0; dataadr = '0; writedata = '0;
        test_reset();
        test_scratch_pass();
        test_mismatch();
        test_timeout();
        test_timeout_edge();
        test_reset_midrun();
        test_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DATA_W, default 32, data bus width.
REQ-002 Parameter ADDR_W, default 32, address bus width.
REQ-003 Parameter DEPTH, default 8, expected-write table entries (>=1).
REQ-004 Parameter TIMEOUT, default 20, cycles allowed in RUN before timeout (>=1).
REQ-005 Parameters SCRATCH_LO/SCRATCH_HI, default 80/80, inclusive ignored address window.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins a check run.
REQ-009 load_valid  input  1  appends {load_addr, load_data} to the table.
REQ-010 load_addr / load_data  input  ADDR_W / DATA_W  expected entry.
REQ-011 memwrite  input  1  monitored store strobe.
REQ-012 dataadr / writedata  input  ADDR_W / DATA_W  monitored store address and data.
REQ-013 busy / pass / fail / timeout  output  1 each  state flags, one-hot or all zero.
REQ-014 fail_idx  output  clog2(DEPTH)  table index at mismatch.
REQ-015 fail_addr / fail_data  output  ADDR_W / DATA_W  offending store captured.
REQ-016 match_count  output  clog2(DEPTH+1)  entries matched this run.

Function
REQ-017 States IDLE, RUN, PASS, FAIL, TOUT; busy=1 only in RUN; pass/fail/timeout=1 only in PASS/FAIL/TOUT.
REQ-018 IDLE: load_valid writes entry at index n_loaded and increments n_loaded; ignored when n_loaded==DEPTH.
REQ-019 load_valid outside IDLE is ignored; the table is never modified by a run.
REQ-020 start in IDLE, PASS, FAIL or TOUT with n_loaded>0 -> RUN next cycle; clears match_count, cycle counter, fail_* outputs.
REQ-021 start with n_loaded==0 is ignored; start while in RUN is ignored.
REQ-022 RUN: cycle counter increments every cycle; width clog2(TIMEOUT+1), no wrap.
REQ-023 RUN, memwrite=1, dataadr outside scratch window: compare {dataadr, writedata} to entry[match_count].
REQ-024 Match -> match_count+1; if it was the last loaded entry -> PASS.
REQ-025 Mismatch (address or data) -> FAIL; fail_idx=match_count, fail_addr=dataadr, fail_data=writedata.
REQ-026 Cycle counter reaching TIMEOUT-1 with no completion -> TOUT; match_count retained.
REQ-027 A final match on the timeout cycle wins: PASS, not TOUT; a mismatch on that cycle gives FAIL.
REQ-028 memwrite outside RUN is ignored; comparison sees only the rising-edge sample.
REQ-029 All outputs registered; a store sampled on edge k is reflected in outputs after edge k.
REQ-030 PASS, FAIL and TOUT are sticky until start or reset.

Reset
REQ-031 reset asserted: state IDLE, n_loaded=0, match_count=0, counter=0, all flags 0, fail_* outputs 0; takes effect immediately regardless of clk.
REQ-032 reset mid-run aborts the run and empties the table; table contents need not be cleared.

Configuration
REQ-033 Macro MWC_SCRATCH_EN defined: stores with SCRATCH_LO<=dataadr<=SCRATCH_HI are ignored in RUN.
REQ-034 MWC_SCRATCH_EN undefined: no window; every store in RUN is compared; SCRATCH_* unused.

Verification (DEPTH=4, TIMEOUT=20, MWC_SCRATCH_EN defined unless stated)
REQ-035 Load (84,7); start; stores (80,3) then (84,7) -> pass=1 after the second store edge, match_count=1, busy=0.
REQ-036 Load (84,7); start; store (88,7) -> fail=1, fail_idx=0, fail_addr=88, fail_data=7.
REQ-037 Load (84,7); start; no stores -> timeout=1 exactly 20 cycles after RUN entry, match_count=0.
REQ-038 Load (84,7),(88,9); start; store (84,7); reset in the next cycle -> all outputs 0 at once; a later start does nothing (table empty).
REQ-039 Load 5 entries -> only 4 are kept; a run matching 4 stores gives pass=1, match_count=4.
REQ-040 MWC_SCRATCH_EN undefined; load (84,7); start; store (80,3) -> fail=1, fail_addr=80.
